id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage sitting directly downstream of the register file. Each cycle it captures the decoded instruction and both register read operands into the ID/EX pipeline register. Because the register file's internal write-before-read path is disabled, this stage applies the write-back bypass itself. It also detects load-use hazards, inserts bubbles, and honours flush and downstream hold.

## Interface
Parameters:
- DATA_W, 16, datapath and PC width
- REG_ADDR_W, 4, register specifier width
- OPC_W, 4, opcode width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_SrcReg1, id_SrcReg2, id_DstReg  in  REG_ADDR_W  decoded specifiers
- id_Uses1, id_Uses2  in  1  instruction actually reads SrcReg1 / SrcReg2
- id_RegWrite, id_MemRead, id_MemWrite  in  1  decoded control
- id_Opcode  in  OPC_W;  id_Imm, id_PC  in  DATA_W
- SrcData1, SrcData2  in  DATA_W  register file read data
- wb_DstReg  in  REG_ADDR_W;  wb_WriteReg  in  1;  wb_DstData  in  DATA_W  write-back port, also driven to the register file
- flush  in  1  kill the instruction entering EX (taken branch)
- ex_hold  in  1  downstream stall; freeze this stage
- id_stall  out  1  combinational; upstream must hold PC and IF/ID
- ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite  out  1
- ex_SrcReg1, ex_SrcReg2, ex_DstReg  out  REG_ADDR_W;  ex_Opcode  out  OPC_W
- ex_A, ex_B, ex_Imm, ex_PC  out  DATA_W  registered operands / fields

## Operation
- Bypass:
  - A_next = (wb_WriteReg && wb_DstReg == id_SrcReg1) ? wb_DstData : SrcData1.
  - B_next is the same, using id_SrcReg2 / SrcData2.
  - No R0 special case; register 0 is bypassed like any other register.
- Load-use hazard: luh = id_valid & ex_valid & ex_MemRead & ex_RegWrite & ((id_Uses1 & id_SrcReg1 == ex_DstReg) | (id_Uses2 & id_SrcReg2 == ex_DstReg)).
- Update priority, highest first, evaluated each rising edge:
  1. rst: every ex_* output is cleared to 0.
  2. flush: insert a bubble, i.e. every ex_* output is cleared to 0.
  3. ex_hold: all ex_* registers keep their values.
  4. luh: insert a bubble (all ex_* cleared to 0).
  5. Otherwise capture. ex_valid <= id_valid. The three control flags are ANDed with id_valid. Specifiers, opcode, Imm, PC, A_next and B_next are loaded.
- id_stall = ~rst & ~flush & (ex_hold | luh).
- Bubble state is indistinguishable from the reset state.

## Timing
- Capture latency: 1 cycle, ID inputs to ex_* outputs.
- Bypass is same-cycle. A write-back in cycle N to a register read in cycle N delivers wb_DstData on ex_A/ex_B in cycle N+1.
- id_stall is combinational from current ex_* state and id_*/flush/ex_hold. There is no registered stall.
- Load-use stalls last exactly 1 cycle:
  - Cycle N: id_stall=1 and a bubble is written.
  - Cycle N+1: ex_MemRead=0, so luh=0 and the dependent instruction is captured.
- luh during ex_hold: hold wins. The hazard is re-evaluated once the hold drops.
- Reset mid-stall or mid-hold: outputs are 0 the next cycle and id_stall=0 while rst=1.

## Structure
- Shared package cpu_pkg holds:
  - DATA_W, REG_ADDR_W and OPC_W constants.
  - Opcode localparams.
  - A packed struct for the ID/EX control bundle (valid, RegWrite, MemRead, MemWrite, Opcode), reused by the EX/MEM stage.
- One sub-module, wb_bypass_mux: specifier compare plus 2:1 data select, instantiated twice (operands A and B).
- Hazard detect and pipeline register stay in the top module.

## Test plan
- Reset: drive rst=1 for 2 cycles with random inputs.
  - Expect all ex_* = 0 and id_stall=0.
- Capture: id_valid=1, SrcReg1=3, SrcData1=0x1234, SrcData2=0x0F0F, Imm=0x00FF, PC=0x0040.
  - Next cycle expect ex_A=0x1234, ex_B=0x0F0F, ex_Imm=0x00FF, ex_PC=0x0040, ex_valid=1.
  - With id_valid=0 and id_RegWrite=1, expect ex_RegWrite=0.
- Bypass: id_SrcReg2=5, SrcData2=0xAAAA, wb_WriteReg=1, wb_DstReg=5, wb_DstData=0x5555.
  - Expect ex_B=0x5555.
  - With wb_WriteReg=0, expect ex_B=0xAAAA.
  - With wb_DstReg=6, expect ex_B=0xAAAA.
- Load-use: EX holds a load (MemRead=1, RegWrite=1, DstReg=4); ID has id_Uses1=1, SrcReg1=4.
  - Expect id_stall=1 and ex_valid=0 next cycle.
  - The cycle after, expect the instruction captured and id_stall=0.
  - Repeat with id_Uses1=0: expect no stall.
- Hold/flush: ex_hold=1 for 3 cycles.
  - Expect ex_* unchanged and id_stall=1 throughout.
  - Then assert flush=1 together with ex_hold=1: expect id_stall=0 and ex_valid=0 next cycle.
- Reset mid-stall: assert rst during a load-use stall cycle.
  - Expect all outputs 0 next cycle and id_stall=0 while rst=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath widths, opcodes and the ID/EX control bundle.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int OPC_W      = 4;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h4;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'h5;
    localparam logic [OPC_W-1:0] OP_SHR  = 4'h6;
    localparam logic [OPC_W-1:0] OP_LOAD = 4'h8;
    localparam logic [OPC_W-1:0] OP_STOR = 4'h9;
    localparam logic [OPC_W-1:0] OP_BEQ  = 4'hA;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hB;

    // Control bundle carried from ID into EX and onward into EX/MEM.
    typedef struct packed {
        logic             valid;
        logic             regWrite;
        logic             memRead;
        logic             memWrite;
        logic [OPC_W-1:0] opcode;
    } idExCtrl_t;

endpackage

// File: rtl/wb_bypass_mux.sv
// Write-back bypass for one register read operand: replaces stale register file data
// with the value being written back this cycle.
module wb_bypass_mux import cpu_pkg::*; #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] srcReg,
    input  logic [DATA_W-1:0]     srcData,
    input  logic [REG_ADDR_W-1:0] wbDstReg,
    input  logic                  wbWriteReg,
    input  logic [DATA_W-1:0]     wbDstData,
    output logic [DATA_W-1:0]     opData
);

    // Register 0 is not special here; it bypasses like any other register.
    assign opData = (wbWriteReg && (wbDstReg == srcReg)) ? wbDstData : srcData;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// flush and downstream hold.
module id_ex_stage import cpu_pkg::*; #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int OPC_W      = cpu_pkg::OPC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_SrcReg1,
    input  logic [REG_ADDR_W-1:0] id_SrcReg2,
    input  logic [REG_ADDR_W-1:0] id_DstReg,
    input  logic                  id_Uses1,
    input  logic                  id_Uses2,
    input  logic                  id_RegWrite,
    input  logic                  id_MemRead,
    input  logic                  id_MemWrite,
    input  logic [OPC_W-1:0]      id_Opcode,
    input  logic [DATA_W-1:0]     id_Imm,
    input  logic [DATA_W-1:0]     id_PC,
    input  logic [DATA_W-1:0]     SrcData1,
    input  logic [DATA_W-1:0]     SrcData2,
    input  logic [REG_ADDR_W-1:0] wb_DstReg,
    input  logic                  wb_WriteReg,
    input  logic [DATA_W-1:0]     wb_DstData,
    input  logic                  flush,
    input  logic                  ex_hold,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic                  ex_RegWrite,
    output logic                  ex_MemRead,
    output logic                  ex_MemWrite,
    output logic [REG_ADDR_W-1:0] ex_SrcReg1,
    output logic [REG_ADDR_W-1:0] ex_SrcReg2,
    output logic [REG_ADDR_W-1:0] ex_DstReg,
    output logic [OPC_W-1:0]      ex_Opcode,
    output logic [DATA_W-1:0]     ex_A,
    output logic [DATA_W-1:0]     ex_B,
    output logic [DATA_W-1:0]     ex_Imm,
    output logic [DATA_W-1:0]     ex_PC
);

    logic [DATA_W-1:0] aNext;
    logic [DATA_W-1:0] bNext;
    logic              loadUse;

    idExCtrl_t             ctrl_p1;
    logic [REG_ADDR_W-1:0] srcReg1_p1;
    logic [REG_ADDR_W-1:0] srcReg2_p1;
    logic [REG_ADDR_W-1:0] dstReg_p1;
    logic [DATA_W-1:0]     opA_p1;
    logic [DATA_W-1:0]     opB_p1;
    logic [DATA_W-1:0]     imm_p1;
    logic [DATA_W-1:0]     pc_p1;

    wb_bypass_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bypassA (
        .srcReg     (id_SrcReg1),
        .srcData    (SrcData1),
        .wbDstReg   (wb_DstReg),
        .wbWriteReg (wb_WriteReg),
        .wbDstData  (wb_DstData),
        .opData     (aNext)
    );

    wb_bypass_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bypassB (
        .srcReg     (id_SrcReg2),
        .srcData    (SrcData2),
        .wbDstReg   (wb_DstReg),
        .wbWriteReg (wb_WriteReg),
        .wbDstData  (wb_DstData),
        .opData     (bNext)
    );

    // A load in EX whose destination is read by the decoding instruction needs one bubble.
    assign loadUse = id_valid & ctrl_p1.valid & ctrl_p1.memRead & ctrl_p1.regWrite &
                     ((id_Uses1 & (id_SrcReg1 == dstReg_p1)) |
                      (id_Uses2 & (id_SrcReg2 == dstReg_p1)));

    assign id_stall = ~rst & ~flush & (ex_hold | loadUse);

    // ID -> EX register: a bubble is the same all-zero state as reset.
    always_ff @(posedge clk) begin
        if (rst || flush || (!ex_hold && loadUse)) begin
            ctrl_p1    <= '0;
            srcReg1_p1 <= '0;
            srcReg2_p1 <= '0;
            dstReg_p1  <= '0;
            opA_p1     <= '0;
            opB_p1     <= '0;
            imm_p1     <= '0;
            pc_p1      <= '0;
        end else if (!ex_hold) begin
            ctrl_p1.valid    <= id_valid;
            ctrl_p1.regWrite <= id_RegWrite & id_valid;
            ctrl_p1.memRead  <= id_MemRead & id_valid;
            ctrl_p1.memWrite <= id_MemWrite & id_valid;
            ctrl_p1.opcode   <= id_Opcode;
            srcReg1_p1       <= id_SrcReg1;
            srcReg2_p1       <= id_SrcReg2;
            dstReg_p1        <= id_DstReg;
            opA_p1           <= aNext;
            opB_p1           <= bNext;
            imm_p1           <= id_Imm;
            pc_p1            <= id_PC;
        end
    end

    assign ex_valid    = ctrl_p1.valid;
    assign ex_RegWrite = ctrl_p1.regWrite;
    assign ex_MemRead  = ctrl_p1.memRead;
    assign ex_MemWrite = ctrl_p1.memWrite;
    assign ex_Opcode   = ctrl_p1.opcode;
    assign ex_SrcReg1  = srcReg1_p1;
    assign ex_SrcReg2  = srcReg2_p1;
    assign ex_DstReg   = dstReg_p1;
    assign ex_A        = opA_p1;
    assign ex_B        = opB_p1;
    assign ex_Imm      = imm_p1;
    assign ex_PC       = pc_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios followed by random traffic,
// all checked against a behavioural model of the ID/EX register.
module tb_id_ex_stage;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        hold;
        logic        valid;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  dst;
        logic        uses1;
        logic        uses2;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [3:0]  opc;
        logic [15:0] imm;
        logic [15:0] pc;
        logic [15:0] data1;
        logic [15:0] data2;
        logic [3:0]  wbDst;
        logic        wbWr;
        logic [15:0] wbData;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  dst;
        logic [3:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [15:0] pc;
    } exState_t;

    typedef struct packed {
        logic     checkState;
        logic     stall;
        exState_t st;
    } expItem_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t cur;
    logic  idStall;
    exState_t act;

    int total = 0;
    int bad   = 0;
    expItem_t expQ[$];
    exState_t model;
    logic modelKnown;

    id_ex_stage dut (
        .clk         (clk),
        .rst         (cur.rst),
        .id_valid    (cur.valid),
        .id_SrcReg1  (cur.src1),
        .id_SrcReg2  (cur.src2),
        .id_DstReg   (cur.dst),
        .id_Uses1    (cur.uses1),
        .id_Uses2    (cur.uses2),
        .id_RegWrite (cur.rw),
        .id_MemRead  (cur.mr),
        .id_MemWrite (cur.mw),
        .id_Opcode   (cur.opc),
        .id_Imm      (cur.imm),
        .id_PC       (cur.pc),
        .SrcData1    (cur.data1),
        .SrcData2    (cur.data2),
        .wb_DstReg   (cur.wbDst),
        .wb_WriteReg (cur.wbWr),
        .wb_DstData  (cur.wbData),
        .flush       (cur.flush),
        .ex_hold     (cur.hold),
        .id_stall    (idStall),
        .ex_valid    (act.valid),
        .ex_RegWrite (act.rw),
        .ex_MemRead  (act.mr),
        .ex_MemWrite (act.mw),
        .ex_SrcReg1  (act.src1),
        .ex_SrcReg2  (act.src2),
        .ex_DstReg   (act.dst),
        .ex_Opcode   (act.opc),
        .ex_A        (act.a),
        .ex_B        (act.b),
        .ex_Imm      (act.imm),
        .ex_PC       (act.pc)
    );

    // The instruction in ID needs a register that a load currently in EX will produce.
    function automatic logic needsLoadResult(exState_t ex, stim_t s);
        if (!(s.valid && ex.valid && ex.mr && ex.rw)) return 1'b0;
        return (s.uses1 && s.src1 == ex.dst) || (s.uses2 && s.src2 == ex.dst);
    endfunction

    function automatic logic [15:0] readReg(logic [3:0] r, logic [15:0] rfData, stim_t s);
        if (s.wbWr && s.wbDst == r) return s.wbData;
        return rfData;
    endfunction

    function automatic exState_t modelNext(exState_t ex, stim_t s);
        exState_t n;
        if (s.rst || s.flush) return '0;
        if (s.hold) return ex;
        if (needsLoadResult(ex, s)) return '0;
        n.valid = s.valid;
        n.rw    = s.valid && s.rw;
        n.mr    = s.valid && s.mr;
        n.mw    = s.valid && s.mw;
        n.src1  = s.src1;
        n.src2  = s.src2;
        n.dst   = s.dst;
        n.opc   = s.opc;
        n.a     = readReg(s.src1, s.data1, s);
        n.b     = readReg(s.src2, s.data2, s);
        n.imm   = s.imm;
        n.pc    = s.pc;
        return n;
    endfunction

    function automatic stim_t idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s.rst    = ($urandom_range(0, 39) == 0);
        s.flush  = ($urandom_range(0, 9) == 0);
        s.hold   = ($urandom_range(0, 5) == 0);
        s.valid  = ($urandom_range(0, 4) != 0);
        s.src1   = 4'($urandom_range(0, 3));
        s.src2   = 4'($urandom_range(0, 3));
        s.dst    = 4'($urandom_range(0, 3));
        s.uses1  = 1'($urandom);
        s.uses2  = 1'($urandom);
        s.rw     = ($urandom_range(0, 3) != 0);
        s.mr     = 1'($urandom);
        s.mw     = 1'($urandom);
        s.opc    = 4'($urandom);
        s.imm    = 16'($urandom);
        s.pc     = 16'($urandom);
        s.data1  = 16'($urandom);
        s.data2  = 16'($urandom);
        s.wbDst  = 4'($urandom_range(0, 3));
        s.wbWr   = 1'($urandom);
        s.wbData = 16'($urandom);
        return s;
    endfunction

    // Drive one cycle's inputs just after the edge and record what the DUT must show this cycle.
    task automatic cycle(input stim_t s);
        expItem_t it;
        @(posedge clk);
        #1;
        cur = s;
        it.checkState = modelKnown;
        it.stall      = !s.rst && !s.flush && (s.hold || needsLoadResult(model, s));
        it.st         = model;
        expQ.push_back(it);
        model      = modelNext(model, s);
        modelKnown = 1'b1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%04h expected 0x%04h", name, $time, got, want);
        end
    endtask

    // Monitor: compare against the oldest outstanding expectation at every falling edge.
    initial begin
        expItem_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("id_stall", 16'(idStall), 16'(e.stall));
                if (e.checkState) begin
                    chk("ex_valid",    16'(act.valid), 16'(e.st.valid));
                    chk("ex_RegWrite", 16'(act.rw),    16'(e.st.rw));
                    chk("ex_MemRead",  16'(act.mr),    16'(e.st.mr));
                    chk("ex_MemWrite", 16'(act.mw),    16'(e.st.mw));
                    chk("ex_SrcReg1",  16'(act.src1),  16'(e.st.src1));
                    chk("ex_SrcReg2",  16'(act.src2),  16'(e.st.src2));
                    chk("ex_DstReg",   16'(act.dst),   16'(e.st.dst));
                    chk("ex_Opcode",   16'(act.opc),   16'(e.st.opc));
                    chk("ex_A",        act.a,          e.st.a);
                    chk("ex_B",        act.b,          e.st.b);
                    chk("ex_Imm",      act.imm,        e.st.imm);
                    chk("ex_PC",       act.pc,         e.st.pc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        stim_t ld;
        model      = '0;
        modelKnown = 1'b0;
        cur        = idle();
        cur.rst    = 1'b1;

        // Reset with random inputs on the pins
        for (int i = 0; i < 2; i++) begin
            s = randStim();
            s.rst = 1'b1;
            cycle(s);
        end

        // Capture, then an invalid slot must not carry RegWrite
        s = idle();
        s.valid = 1'b1; s.src1 = 4'd3; s.src2 = 4'd7; s.data1 = 16'h1234; s.data2 = 16'h0F0F;
        s.imm = 16'h00FF; s.pc = 16'h0040; s.opc = 4'h2; s.dst = 4'd9; s.rw = 1'b1;
        cycle(s);
        s = idle();
        s.valid = 1'b0; s.rw = 1'b1; s.mr = 1'b1; s.mw = 1'b1;
        cycle(s);

        // Bypass on operand B: matching write-back, write disabled, different register
        s = idle();
        s.valid = 1'b1; s.src2 = 4'd5; s.data2 = 16'hAAAA;
        s.wbWr = 1'b1; s.wbDst = 4'd5; s.wbData = 16'h5555;
        cycle(s);
        s.wbWr = 1'b0;
        cycle(s);
        s.wbWr = 1'b1; s.wbDst = 4'd6;
        cycle(s);
        // Register 0 bypasses too, on both operands
        s = idle();
        s.valid = 1'b1; s.data1 = 16'h1111; s.data2 = 16'h2222;
        s.wbWr = 1'b1; s.wbDst = 4'd0; s.wbData = 16'hBEEF;
        cycle(s);

        // Load-use: one bubble, then the dependent instruction is captured
        ld = idle();
        ld.valid = 1'b1; ld.rw = 1'b1; ld.mr = 1'b1; ld.dst = 4'd4; ld.opc = 4'h8; ld.pc = 16'h0100;
        cycle(ld);
        s = idle();
        s.valid = 1'b1; s.uses1 = 1'b1; s.src1 = 4'd4; s.data1 = 16'h7777; s.pc = 16'h0102; s.rw = 1'b1;
        cycle(s);
        cycle(s);
        // Same registers but the operand is not actually read: no stall
        cycle(ld);
        s.uses1 = 1'b0;
        cycle(s);
        // Dependency through operand 2
        cycle(ld);
        s.uses2 = 1'b1; s.src2 = 4'd4;
        cycle(s);
        cycle(s);

        // Hold for three cycles with changing inputs, then flush during hold
        s = idle();
        s.valid = 1'b1; s.rw = 1'b1; s.mw = 1'b1; s.dst = 4'd2; s.imm = 16'hC0DE; s.pc = 16'h0200;
        s.data1 = 16'hABCD; s.data2 = 16'h4321; s.opc = 4'h9;
        cycle(s);
        for (int i = 0; i < 3; i++) begin
            s = randStim();
            s.rst = 1'b0; s.flush = 1'b0; s.hold = 1'b1;
            cycle(s);
        end
        s.flush = 1'b1;
        cycle(s);
        // Load-use arriving during a hold waits for the hold to drop
        cycle(ld);
        s = idle();
        s.valid = 1'b1; s.uses1 = 1'b1; s.src1 = 4'd4; s.hold = 1'b1;
        cycle(s);
        s.hold = 1'b0;
        cycle(s);
        cycle(s);

        // Reset asserted in a load-use stall cycle
        cycle(ld);
        s = idle();
        s.valid = 1'b1; s.uses1 = 1'b1; s.src1 = 4'd4; s.rst = 1'b1;
        cycle(s);
        s.rst = 1'b0;
        cycle(s);

        // Random traffic
        for (int i = 0; i < 600; i++) cycle(randStim());

        cycle(idle());
        repeat (3) @(negedge clk);
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
